seq_pattern_gen: RTL and testbench
==================================

SEQ_PATTERN_GEN -- requirements
Module: seq_pattern_gen

Interface
REQ-001 Parameter PAT_W, default 4, pattern length in bits (2..16).
REQ-002 Parameter PATTERN, default 4'b0110, serial pattern, transmitted MSB first.
REQ-003 Parameter GAP, default 2, idle cycles between repetitions (0..15).
REQ-004 Port clk  input  1  rising-edge clock.
REQ-005 Port reset  input  1  reset, asynchronous, active-high.
REQ-006 Port start  input  1  request to transmit; sampled only in IDLE.
REQ-007 Port count  input  4  repetitions to send; latched on accepted start.
REQ-008 Port abort  input  1  terminate transmission at next edge.
REQ-009 Port x  output  1  registered serial data; idle level 1.
REQ-010 Port valid  output  1  high while x carries a pattern bit.
REQ-011 Port busy  output  1  high in any state other than IDLE.
REQ-012 Port done  output  1  one-cycle pulse on normal completion.

Function
REQ-013 States: IDLE, SHIFT, GAP, DONE; all outputs registered.
REQ-014 IDLE: x=1, valid=0, busy=0; start=1 and abort=0 at an edge -> latch count, bit index=PAT_W-1, go to SHIFT (count!=0) or DONE (count==0).
REQ-015 SHIFT: x=PATTERN[index], valid=1; the first pattern bit appears in the cycle after the accepting edge.
REQ-016 SHIFT: index decrements each cycle; at index 0, decrement the remaining-repetition counter.
REQ-017 Index 0 with remaining>1: go to GAP if GAP>0, else reload index and stay in SHIFT (back-to-back patterns).
REQ-018 Index 0 with remaining==1: go to DONE.
REQ-019 GAP: x=1, valid=0 for exactly GAP cycles, then SHIFT with index reloaded to PAT_W-1.
REQ-020 DONE: done=1, x=1, valid=0, busy=1 for one cycle, then IDLE; no gap follows the final repetition.
REQ-021 A repetition of N transmits exactly N*PAT_W valid bits and (N-1)*GAP gap cycles.
REQ-022 start while busy is ignored; count changes while busy have no effect.
REQ-023 abort in SHIFT or GAP: IDLE at the next edge, x=1, valid=0, no done pulse; a partial pattern is not completed.
REQ-024 abort in IDLE or DONE has no effect, except that abort=1 blocks start acceptance in IDLE.
REQ-025 In DONE, start is not sampled; start is accepted no earlier than the first IDLE cycle.

Reset
REQ-026 reset=1 forces IDLE immediately: x=1, valid=0, busy=0, done=0; counters cleared.
REQ-027 Reset mid-transmission discards the transmission and produces no done pulse.
REQ-028 After reset deassertion, the first start is accepted at the first rising edge.

Configuration
REQ-029 Macro SEQ_GEN_LOOP_EN: when defined, count==0 selects continuous mode, which repeats PATTERN plus GAP indefinitely until abort or reset, with no done pulse.
REQ-030 When SEQ_GEN_LOOP_EN is not defined, count==0 goes directly to DONE, giving one done pulse, no valid bits, and x held at 1.

Verification
REQ-031 Defaults, count=2, start pulse -> x from the next cycle = 0,1,1,0,1,1,0,1,1,0; valid = 1111 00 1111; done pulse in the following cycle; busy low after that cycle.
REQ-032 GAP=0, count=3 -> 12 consecutive valid bits 011001100110, then done.
REQ-033 count=5, abort asserted on the 6th valid bit -> IDLE at the next edge, x=1, done never asserted, busy=0.
REQ-034 start held high continuously with count=1 -> patterns separated by DONE and IDLE cycles (0110, done, idle, 0110...); start is ignored while busy.
REQ-035 reset asserted asynchronously mid-SHIFT -> outputs x=1, valid=0, busy=0 immediately, without waiting for a clock edge.
REQ-036 count=0 -> without SEQ_GEN_LOOP_EN, a single done pulse and no valid bits; with the macro defined, 0110 11 repeats until abort.

Source files
------------

// File: rtl/seq_pattern_gen.sv
// rtl/seq_pattern_gen.sv - serial pattern generator with repeat count, inter-pattern gap and abort
// Define SEQ_GEN_LOOP_EN to make count==0 repeat the pattern until abort or reset.
module seq_pattern_gen #(
  parameter int              PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b0110,
  parameter int              GAP     = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] count,
  input  logic       abort,
  output logic       x,
  output logic       valid,
  output logic       busy,
  output logic       done
);

  localparam int             IW       = $clog2(PAT_W);
  localparam logic [IW-1:0]  IDX_TOP  = IW'(PAT_W - 1);
  localparam logic [3:0]     GAP_LAST = 4'(GAP - 1);
`ifdef SEQ_GEN_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP, S_DONE} state_t;

  state_t        state;
  logic [IW-1:0] idx;
  logic [3:0]    remaining;
  logic [3:0]    gap_cnt;
  logic          loop_mode;
  logic          more;

  // another repetition follows the one currently finishing
  assign more = loop_mode || (remaining > 4'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      idx       <= '0;
      remaining <= '0;
      gap_cnt   <= '0;
      loop_mode <= 1'b0;
      x         <= 1'b1;
      valid     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && !abort) begin
            remaining <= count;
            loop_mode <= LOOP_EN && (count == 4'd0);
            idx       <= IDX_TOP;
            busy      <= 1'b1;
            if (count != 4'd0 || LOOP_EN) begin
              state <= S_SHIFT;
              x     <= PATTERN[IDX_TOP];
              valid <= 1'b1;
            end else begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end
        end
        S_SHIFT: begin
          if (abort) begin
            state     <= S_IDLE;
            x         <= 1'b1;
            valid     <= 1'b0;
            busy      <= 1'b0;
            loop_mode <= 1'b0;
          end else if (idx != '0) begin
            idx <= idx - 1'b1;
            x   <= PATTERN[idx - 1'b1];
          end else begin
            if (!loop_mode) remaining <= remaining - 4'd1;
            if (!more) begin
              state <= S_DONE;
              x     <= 1'b1;
              valid <= 1'b0;
              done  <= 1'b1;
            end else if (GAP > 0) begin
              state   <= S_GAP;
              gap_cnt <= GAP_LAST;
              x       <= 1'b1;
              valid   <= 1'b0;
            end else begin
              idx <= IDX_TOP;
              x   <= PATTERN[IDX_TOP];
            end
          end
        end
        S_GAP: begin
          if (abort) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            loop_mode <= 1'b0;
          end else if (gap_cnt == 4'd0) begin
            state <= S_SHIFT;
            idx   <= IDX_TOP;
            x     <= PATTERN[IDX_TOP];
            valid <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt - 4'd1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_pattern_gen.sv
// tb/tb_seq_pattern_gen.sv - scoreboard bench for seq_pattern_gen
module tb_seq_pattern_gen;

  localparam int PAT_W = 4;
  localparam logic [PAT_W-1:0] PATTERN = 4'b0110;
  localparam int GAP = 2;
  localparam int EV_DONE = 2;
  localparam int EV_GAP  = 3;

  logic       clk = 1'b0;
  logic       reset, start, abort;
  logic [3:0] count;
  logic       x, valid, busy, done;

  int n_cmp = 0;
  int n_bad = 0;
  int expq[$];
  int model[$];
  bit mon_en = 1'b0;
  int mon_got, mon_exp;

  seq_pattern_gen #(.PAT_W(PAT_W), .PATTERN(PATTERN), .GAP(GAP)) dut (
    .clk(clk), .reset(reset), .start(start), .count(count), .abort(abort),
    .x(x), .valid(valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Every busy cycle is one output event: a pattern bit, a gap cycle or the done pulse.
  always @(negedge clk) begin
    if (mon_en && !reset) begin
      if (busy) begin
        mon_got = valid ? int'(x) : (done ? EV_DONE : EV_GAP);
        if (expq.size() == 0) begin
          check("unexpected_output", mon_got, -1);
        end else begin
          mon_exp = expq.pop_front();
          check("event", mon_got, mon_exp);
          if (!valid) check("x_high_when_not_valid", int'(x), 1);
        end
      end else begin
        check("idle_x", int'(x), 1);
        check("idle_valid", int'(valid), 0);
        check("idle_done", int'(done), 0);
      end
    end
  end

  // Expected event list for a start with the given count: N patterns MSB first,
  // GAP idle cycles between them, one done pulse at the end.
  task automatic build_model(input int cnt);
    int reps;
    bit loop_mode;
    int p;
    p = int'(PATTERN);
    model.delete();
    loop_mode = 1'b0;
    reps = cnt;
`ifdef SEQ_GEN_LOOP_EN
    if (cnt == 0) begin
      loop_mode = 1'b1;
      reps = 3;
    end
`endif
    for (int r = 0; r < reps; r++) begin
      for (int b = PAT_W - 1; b >= 0; b--) model.push_back((p >> b) & 1);
      if (r < reps - 1 || loop_mode)
        for (int g = 0; g < GAP; g++) model.push_back(EV_GAP);
    end
    if (!loop_mode) model.push_back(EV_DONE);
  endtask

  // abort_at: index of the event during which abort is held high (-1: none)
  task automatic run_txn(input int cnt, input int abort_at_in, input bit noisy);
    int abort_at;
    int n;
    abort_at = abort_at_in;
    build_model(cnt);
`ifdef SEQ_GEN_LOOP_EN
    if (cnt == 0 && abort_at < 0) abort_at = model.size() - 1;
`endif
    if (abort_at >= model.size()) abort_at = -1;
    if (abort_at >= 0)
      while (model.size() > abort_at + 1) void'(model.pop_back());
    foreach (model[i]) expq.push_back(model[i]);
    n = model.size();
    start = 1'b1;
    count = 4'(cnt);
    @(negedge clk);
    check("first_output_latency", int'(valid | done), 1);
    for (int i = 0; i < n; i++) begin
      abort = (i == abort_at);
      start = 1'b0;
      if (noisy) begin
        start = 1'($urandom_range(0, 1));
        count = 4'($urandom);
      end
      if (i == n - 1) start = 1'b0;
      @(negedge clk);
    end
    abort = 1'b0;
    start = 1'b0;
    check("busy_low_after_txn", int'(busy), 0);
    check("queue_drained", expq.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ab;
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    count = 4'd0;
    #1;
    check("reset_x", int'(x), 1);
    check("reset_valid", int'(valid), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    mon_en = 1'b1;

    run_txn(2, -1, 1'b0);   // 0110 11 0110, done
    run_txn(5, 7, 1'b0);    // abort on the 6th valid bit
    run_txn(3, 4, 1'b0);    // abort during a gap cycle
    run_txn(0, 9, 1'b0);    // count 0
    run_txn(1, 4, 1'b0);    // abort in DONE is ignored
    run_txn(15, -1, 1'b1);  // longest run with noise on start/count

    // abort blocks start in IDLE
    abort = 1'b1;
    start = 1'b1;
    count = 4'd2;
    @(negedge clk);
    check("abort_blocks_start", int'(busy), 0);
    abort = 1'b0;
    start = 1'b0;
    @(negedge clk);

    // start held high: pattern, done, one idle cycle, pattern...
    start = 1'b1;
    count = 4'd1;
    build_model(1);
    repeat (3) foreach (model[i]) expq.push_back(model[i]);
    @(negedge clk);
    for (int r = 0; r < 3; r++) begin
      repeat (PAT_W + 1) @(negedge clk);
      check("held_start_idle_cycle", int'(busy), 0);
      if (r == 2) start = 1'b0;
      @(negedge clk);
    end
    check("held_start_drained", expq.size(), 0);
    check("held_start_stopped", int'(busy), 0);

    // asynchronous reset mid-SHIFT
    build_model(5);
    foreach (model[i]) expq.push_back(model[i]);
    start = 1'b1;
    count = 4'd5;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_reset_x", int'(x), 1);
    check("async_reset_valid", int'(valid), 0);
    check("async_reset_busy", int'(busy), 0);
    check("async_reset_done", int'(done), 0);
    expq.delete();
    @(negedge clk);
    reset = 1'b0;
    run_txn(1, -1, 1'b0);   // accepted at the first edge after reset

    repeat (40) begin
      ab = -1;
      if ($urandom_range(0, 3) == 0) ab = int'($urandom_range(0, 60));
      run_txn(int'($urandom_range(0, 15)), ab, 1'b1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
